// File: rtl/fifo_fwft_ctrl_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFO controller.
// The dual-clock variant is meant to reuse this package.
package fifo_fwft_ctrl_pkg;

    // Output stage holds one presented word plus one skid word.
    localparam int OUT_SLOTS = 2;

    function automatic bit depth_ok(input int addr_w, input int depth);
        return depth == (1 << addr_w);
    endfunction

endpackage

// File: rtl/fifo_fwft_ctrl.sv
// FWFT stream FIFO controller around an external 1-cycle-latency dual-port RAM.
// Owns the pointers, the full/empty logic and a 2-entry output stage that hides the read latency.
module fifo_fwft_ctrl
    import fifo_fwft_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int RAM_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH+1:0] count
);

    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH+1:0] cnt_t;

    if (!depth_ok(ADDR_WIDTH, RAM_DEPTH)) begin : g_depth_check
        $error("fifo_fwft_ctrl: RAM_DEPTH must equal 2**ADDR_WIDTH");
    end

    function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
        return a - b;
    endfunction

    ptr_t                  wptr;
    ptr_t                  rptr;
    ptr_t                  ram_cnt;
    logic                  ram_full;
    logic                  ram_empty;
    logic                  rd_pend;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  push;
    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            occ_after;
    logic                  land_out;
    logic                  load_skid;

    assign ram_cnt   = ptr_diff(wptr, rptr);
    assign ram_full  = (ram_cnt == ptr_t'(RAM_DEPTH));
    assign ram_empty = (ram_cnt == '0);

    assign in_ready  = rst_n & ~ram_full;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Issue a read only if the landing word is guaranteed a free output slot.
    assign occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
    assign occ_after = occ - {1'b0, pop};
    assign ram_rd_en = ~ram_empty & (occ_after < 2'(OUT_SLOTS));

    assign ram_wr_en = push;
    assign ram_wdata = in_data;
    assign ram_waddr = wptr[ADDR_WIDTH-1:0];
    assign ram_raddr = rptr[ADDR_WIDTH-1:0];

    assign land_out  = rd_pend & (~out_valid | (pop & ~skid_valid));
    assign load_skid = rd_pend & out_valid & ~(pop & ~skid_valid);

    assign count = cnt_t'(ram_cnt) + cnt_t'(rd_pend) + cnt_t'(out_valid) + cnt_t'(skid_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_pend <= 1'b0;
        end else begin
            wptr    <= wptr + ptr_t'(push);
            rptr    <= rptr + ptr_t'(ram_rd_en);
            rd_pend <= ram_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
        end else if (land_out) begin
            out_valid <= 1'b1;
            out_data  <= ram_rdata;
        end else if (rd_pend) begin
            // Landing word goes to skid; on a pop the old skid word advances first.
            skid_valid <= 1'b1;
            if (pop) begin
                out_data <= skid_data;
            end
        end else if (pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_fwft_ctrl.sv
// Bench for fifo_fwft_ctrl with a behavioural RAM and a queue-based reference model.
module tb_fifo_fwft_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ram_wdata;
    logic [1:0] ram_waddr;
    logic       ram_wr_en;
    logic [1:0] ram_raddr;
    logic       ram_rd_en;
    logic [7:0] ram_rdata;
    logic [3:0] count;

    logic [7:0] mem [4];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    bit         was_stall;
    int         starve;
    int         pops;
    bit         last_push;

    always #5 clk = ~clk;

    fifo_fwft_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RAM_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_wdata(ram_wdata), .ram_waddr(ram_waddr), .ram_wr_en(ram_wr_en),
        .ram_raddr(ram_raddr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
        .count(count)
    );

    // Dual-port RAM with registered read port
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_waddr] <= ram_wdata;
        if (ram_rd_en) ram_rdata <= mem[ram_raddr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check DUT against the model mid-cycle, then apply the handshakes at the edge.
    task automatic step();
        logic       p_push;
        logic       p_pop;
        logic [7:0] p_data;
        @(negedge clk);
        check_val("count", 32'(count), 32'(q.size()));
        if (q.size() == 0) check_val("idle_valid", 32'(out_valid), 32'd0);
        else if (out_valid) check_val("head_data", 32'(out_data), 32'(q[0]));
        if (q.size() > 0) begin
            starve = out_valid ? 0 : starve + 1;
            check_val("fwft_latency", 32'(starve <= 2), 32'd1);
        end else begin
            starve = 0;
        end
        if (was_stall) check_val("hold_valid", 32'(out_valid), 32'd1);
        if (q.size() >= 6) check_val("full_ready", 32'(in_ready), 32'd0);
        if (q.size() <= 3) check_val("free_ready", 32'(in_ready), 32'd1);
        p_push    = in_valid & in_ready;
        p_pop     = out_valid & out_ready;
        p_data    = in_data;
        was_stall = out_valid & ~out_ready;
        @(posedge clk);
        if (p_pop && q.size() > 0) void'(q.pop_front());
        if (p_push) q.push_back(p_data);
        if (p_pop) pops++;
        last_push = p_push;
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        check_val("drained", 32'(q.size()), 32'd0);
        step();
        out_ready = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_count"}, 32'(count), 32'd0);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_wr_en"}, 32'(ram_wr_en), 32'd0);
        check_val({tag, "_rd_en"}, 32'(ram_rd_en), 32'd0);
        check_val({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int         d;
        int         acc;
        logic [7:0] first_out;
        bit         seen;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        was_stall = 1'b0; starve = 0; pops = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check_val("release_in_ready", 32'(in_ready), 32'd1);

        // Single word with the consumer stalled
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        check_val("single_rd_en", 32'(ram_rd_en), 32'd1);
        check_val("single_vld_e1", 32'(out_valid), 32'd0);
        step();
        check_val("single_vld_e2", 32'(out_valid), 32'd0);
        step();
        check_val("single_vld", 32'(out_valid), 32'd1);
        check_val("single_data", 32'(out_data), 32'hA5);
        check_val("single_count", 32'(count), 32'd1);
        repeat (3) step();
        check_val("single_hold", 32'(out_data), 32'hA5);
        drain();

        // Fill with the consumer stalled
        d = 1; acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = 8'(d);
            step();
            if (last_push) begin
                acc++;
                if (d < 7) d++;
            end
        end
        check_val("fill_accepted", 32'(acc), 32'd6);
        check_val("fill_in_ready", 32'(in_ready), 32'd0);
        check_val("fill_count", 32'(count), 32'd6);
        check_val("fill_head", 32'(out_data), 32'h01);
        drain();

        // Streaming at full rate
        pops = 0; acc = 0; d = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(d);
            step();
            if (last_push) begin acc++; d++; end
            if (i >= 2) check_val("stream_gap", 32'(out_valid), 32'd1);
        end
        check_val("stream_pushes", 32'(acc), 32'd100);
        check_val("stream_pops", 32'(pops), 32'd97);
        drain();

        // Random traffic on both sides
        acc = 0;
        in_data = 8'($urandom);
        for (int i = 0; i < 20000 && acc < 1000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            step();
            if (last_push) begin
                acc++;
                in_data = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        check_val("rand_words", 32'(acc), 32'd1000);
        drain();

        // Pointer wrap with a lag of three words
        acc = 0; pops = 0;
        for (int i = 0; i < 100 && pops < 12; i++) begin
            in_valid  = (acc < 12);
            out_ready = (acc >= 3);
            in_data   = 8'(8'h80 + acc);
            step();
            if (last_push) acc++;
        end
        check_val("wrap_pops", 32'(pops), 32'd12);
        drain();

        // Reset in the middle of a burst: count 5 with a read in flight
        d = 8'h40;
        for (int i = 0; i < 30 && q.size() < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(d);
            step();
            if (last_push) d++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("pre_reset_count", 32'(count), 32'd5);
        check_val("pre_reset_pend", 32'(dut.rd_pend), 32'd1);
        #1 rst_n = 1'b0;
        in_valid = 1'b1; in_data = 8'hEE;
        #1;
        reset_checks("mid_reset");
        q.delete(); was_stall = 1'b0; starve = 0;
        @(posedge clk) #1;
        reset_checks("mid_reset_held");
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check_val("post_reset_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        seen = 1'b0; first_out = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) begin seen = 1'b1; first_out = out_data; end
            else step();
        end
        check_val("post_reset_seen", 32'(seen), 32'd1);
        check_val("post_reset_first", 32'(first_out), 32'h3C);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
